draw_column_sequencer: RTL and testbench
========================================

DRAW_COLUMN_SEQUENCER -- requirements
Module: draw_column_sequencer

Interface
REQ-001 Parameter SCREEN_W, default 160, number of columns per frame.
REQ-002 Parameter SCREEN_H, default 120, number of rows per column.
REQ-003 Parameter CALC_TIMEOUT, default 255, maximum cycles to wait for a slice result.
REQ-004 Parameters WALL_COLOUR / CEIL_COLOUR / FLOOR_COLOUR, defaults 3'b100 / 3'b001 / 3'b010, 3-bit RGB pixel colours.
REQ-005 clock  input  1  system clock.
REQ-006 resetn  input  1  reset, synchronous, active-low.
REQ-007 start_frame  input  1  request to render one full frame; sampled only in IDLE.
REQ-008 calc_begin  output  1  one-cycle start pulse to the slice-height calculator.
REQ-009 column_count  output  8  current column index presented to the calculator.
REQ-010 calc_done  input  1  calculator completion flag (level); only its rising edge is meaningful.
REQ-011 slice_size  input  7  unsigned projected wall height, valid on the calc_done rising edge.
REQ-012 plot  output  1  pixel write enable to the VGA adapter.
REQ-013 x  output  8  pixel column (equals column_count).
REQ-014 y  output  7  pixel row.
REQ-015 colour  output  3  pixel colour.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 frame_done  output  1  one-cycle pulse after the last pixel of the frame.

Function
REQ-018 FSM states SHALL be IDLE, REQ, WAIT, DRAW, NEXT, DONE.
REQ-019 IDLE: all outputs low; start_frame=1 -> column_count<=0, go to REQ.
REQ-020 REQ: calc_begin=1 for exactly one cycle; clear the timeout counter; go to WAIT.
REQ-021 WAIT: calc_begin=0; the block SHALL register calc_done each cycle (done_q) and treat calc_done=1 AND done_q=0 as the result event.
REQ-022 A calc_done level that is already high on entry to WAIT SHALL NOT be accepted; only a fresh rising edge is accepted.
REQ-023 On the result event: h = min(slice_size, SCREEN_H); top = (SCREEN_H - h) >> 1; bottom = top + h; row<=0; go to DRAW.
REQ-024 If the timeout counter reaches CALC_TIMEOUT with no result event, the block SHALL latch h=0 and go to DRAW; the column is then drawn as ceiling and floor only.
REQ-025 A result event and a timeout in the same cycle SHALL resolve in favour of the result event.
REQ-026 DRAW: plot=1, x=column_count, y=row; colour = CEIL_COLOUR if row<top, WALL_COLOUR if top<=row<bottom, FLOOR_COLOUR otherwise; row increments each cycle; row=SCREEN_H-1 -> NEXT.
REQ-027 NEXT: plot=0; if column_count=SCREEN_W-1 go to DONE, else increment column_count and go to REQ.
REQ-028 DONE: frame_done=1 for one cycle; go to IDLE.
REQ-029 start_frame SHALL be ignored in every state except IDLE.
REQ-030 Column latency SHALL be 1 (REQ) + k (WAIT, up to and including the edge cycle) + SCREEN_H (DRAW) + 1 (NEXT) cycles.
REQ-031 Arithmetic: top and bottom SHALL be 7-bit unsigned; when h is odd, the extra row SHALL fall on the floor side.

Reset
REQ-032 While resetn=0 at a clock edge: state<=IDLE; column_count, row, h, top, bottom, done_q and the timeout counter <=0.
REQ-033 All outputs SHALL be 0 in the cycle following reset.
REQ-034 A reset asserted mid-frame SHALL abort the frame with no frame_done pulse.

Structure
REQ-035 Package slice_draw_pkg SHALL hold SCREEN_W, SCREEN_H, the colour constants and the FSM state encoding.
REQ-036 Sub-module slice_bounds SHALL be combinational: it takes slice_size and produces the clamped h, top and bottom.

Verification
REQ-037 slice_size=40 on the first edge -> top=40, bottom=80; rows 0-39 ceiling, 40-79 wall, 80-119 floor; 120 plot cycles at x=0.
REQ-038 slice_size=127 -> clamped to 120; all 120 rows WALL_COLOUR.
REQ-039 slice_size=41 -> top=39, bottom=80; floor starts at row 80.
REQ-040 calc_done held high from before REQ and never re-edged -> timeout after 255 cycles; column drawn with h=0 (rows 0-59 ceiling, 60-119 floor).
REQ-041 Full frame with calc_done edge 3 cycles after each calc_begin -> 160 calc_begin pulses, 19200 plot cycles, exactly one frame_done, start_frame pulses mid-frame ignored.
REQ-042 resetn=0 at column 57, row 10 -> next cycle plot=0, busy=0, no frame_done; a new start_frame begins again at column 0.

Source files
------------

// File: rtl/draw_column_sequencer_pkg.sv
// Shared screen geometry, palette and FSM encoding
// for the raycaster column sequencer.
package slice_draw_pkg;
  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  localparam logic [2:0] WALL_COLOUR  = 3'b100;
  localparam logic [2:0] CEIL_COLOUR  = 3'b001;
  localparam logic [2:0] FLOOR_COLOUR = 3'b010;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_REQ  = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_DRAW = 3'd3;
  localparam logic [2:0] S_NEXT = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;
endpackage

// File: rtl/draw_column_sequencer_if.sv
// Calculator handshake and VGA pixel bus
// between the sequencer and its neighbours.
interface draw_column_sequencer_if;
  import slice_draw_pkg::*;

  logic       calc_begin;
  logic [7:0] column_count;
  logic       calc_done;
  logic [6:0] slice_size;
  logic       plot;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;

  modport master (
    output calc_begin, column_count,
    output plot, x, y, colour,
    input  calc_done, slice_size
  );

  modport slave (
    input  calc_begin, column_count,
    input  plot, x, y, colour,
    output calc_done, slice_size
  );
endinterface

// File: rtl/draw_column_sequencer_slice_bounds.sv
// Clamps a projected wall height and centres it;
// an odd leftover row lands on the floor side.
module slice_bounds #(
  parameter int SCREEN_H = slice_draw_pkg::SCREEN_H
) (
  input  logic [6:0] i_size,
  output logic [6:0] o_h,
  output logic [6:0] o_top,
  output logic [6:0] o_bottom
);
  import slice_draw_pkg::*;

  localparam logic [6:0] HMAX = 7'(SCREEN_H);

  logic [6:0] w_span;

  assign o_h      = (i_size > HMAX) ? HMAX : i_size;
  assign w_span   = HMAX - o_h;
  assign o_top    = {1'b0, w_span[6:1]};
  assign o_bottom = o_top + o_h;
endmodule

// File: rtl/draw_column_sequencer.sv
// Walks every screen column: asks the calculator for
// a wall height, then paints ceiling/wall/floor rows.
module draw_column_sequencer #(
  parameter int         SCREEN_W     = slice_draw_pkg::SCREEN_W,
  parameter int         SCREEN_H     = slice_draw_pkg::SCREEN_H,
  parameter int         CALC_TIMEOUT = 255,
  parameter logic [2:0] WALL_COLOUR  = slice_draw_pkg::WALL_COLOUR,
  parameter logic [2:0] CEIL_COLOUR  = slice_draw_pkg::CEIL_COLOUR,
  parameter logic [2:0] FLOOR_COLOUR = slice_draw_pkg::FLOOR_COLOUR
) (
  input  logic clock,
  input  logic resetn,
  input  logic start_frame,
  output logic busy,
  output logic frame_done,
  draw_column_sequencer_if.master bus
);
  import slice_draw_pkg::*;

  localparam logic [7:0] LAST_COL = 8'(SCREEN_W - 1);
  localparam logic [6:0] LAST_ROW = 7'(SCREEN_H - 1);
  localparam logic [7:0] TMO_LAST = 8'(CALC_TIMEOUT - 1);

  logic [2:0] r_state;
  logic [7:0] r_col;
  logic [6:0] r_row;
  logic [6:0] r_h;
  logic [6:0] r_top;
  logic [6:0] r_bot;
  logic       r_done_q;
  logic [7:0] r_tmo;

  logic       w_evt;
  logic       w_tmo;
  logic [6:0] w_size;
  logic [6:0] w_h;
  logic [6:0] w_top;
  logic [6:0] w_bot;
  logic       w_plot;
  logic       w_ceil;
  logic       w_wall;
  logic [2:0] w_colour;

  // Only a fresh rising edge counts; it also beats a same-cycle timeout
  assign w_evt  = bus.calc_done & ~r_done_q;
  assign w_tmo  = (r_tmo == TMO_LAST);
  assign w_size = w_evt ? bus.slice_size : 7'd0;

  slice_bounds #(
    .SCREEN_H (SCREEN_H)
  ) u_bounds (
    .i_size   (w_size),
    .o_h      (w_h),
    .o_top    (w_top),
    .o_bottom (w_bot)
  );

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_state  <= S_IDLE;
      r_col    <= 8'd0;
      r_row    <= 7'd0;
      r_h      <= 7'd0;
      r_top    <= 7'd0;
      r_bot    <= 7'd0;
      r_done_q <= 1'b0;
      r_tmo    <= 8'd0;
    end else begin
      r_done_q <= bus.calc_done;
      case (r_state)
        S_IDLE: if (start_frame) begin
          r_col   <= 8'd0;
          r_state <= S_REQ;
        end
        S_REQ: begin
          r_tmo   <= 8'd0;
          r_state <= S_WAIT;
        end
        S_WAIT: if (w_evt || w_tmo) begin
          r_h     <= w_h;
          r_top   <= w_top;
          r_bot   <= w_bot;
          r_row   <= 7'd0;
          r_state <= S_DRAW;
        end else begin
          r_tmo <= r_tmo + 8'd1;
        end
        S_DRAW: if (r_row == LAST_ROW) begin
          r_row   <= 7'd0;
          r_state <= S_NEXT;
        end else begin
          r_row <= r_row + 7'd1;
        end
        S_NEXT: if (r_col == LAST_COL) begin
          r_state <= S_DONE;
        end else begin
          r_col   <= r_col + 8'd1;
          r_state <= S_REQ;
        end
        S_DONE: begin
          r_col   <= 8'd0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_plot = (r_state == S_DRAW);
  assign w_ceil = (r_row < r_top);
  assign w_wall = !w_ceil && (r_row < r_bot) && (r_h != 7'd0);

  always_comb begin
    w_colour = 3'b000;
    if (w_plot) begin
      unique case (1'b1)
        w_ceil:  w_colour = CEIL_COLOUR;
        w_wall:  w_colour = WALL_COLOUR;
        default: w_colour = FLOOR_COLOUR;
      endcase
    end
  end

  assign bus.calc_begin   = (r_state == S_REQ);
  assign bus.column_count = r_col;
  assign bus.plot         = w_plot;
  assign bus.x            = r_col;
  assign bus.y            = r_row;
  assign bus.colour       = w_colour;
  assign busy             = (r_state != S_IDLE);
  assign frame_done       = (r_state == S_DONE);
endmodule

// File: tb/tb_draw_column_sequencer.sv
// Scoreboard bench: plays the slice calculator and
// checks every plotted pixel against its own model.
module tb_draw_column_sequencer;
  import slice_draw_pkg::*;

  localparam int TMO = 255;

  logic clock = 1'b0;
  logic resetn = 1'b0;
  logic start_frame = 1'b0;
  logic busy;
  logic frame_done;

  draw_column_sequencer_if bus ();

  draw_column_sequencer #(
    .SCREEN_W     (SCREEN_W),
    .SCREEN_H     (SCREEN_H),
    .CALC_TIMEOUT (TMO),
    .WALL_COLOUR  (WALL_COLOUR),
    .CEIL_COLOUR  (CEIL_COLOUR),
    .FLOOR_COLOUR (FLOOR_COLOUR)
  ) dut (
    .clock       (clock),
    .resetn      (resetn),
    .start_frame (start_frame),
    .busy        (busy),
    .frame_done  (frame_done),
    .bus         (bus.master)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int t_req = 0;
  int n_begin = 0;
  int n_plot = 0;
  int n_fd = 0;
  int cd_cnt = 0;
  int exp_col = 0;
  int cur_col = 0;
  int sz_idx = 0;
  int dly = 3;
  bit stuck = 1'b0;
  logic [17:0] exp_q[$];
  int lat_q[$];
  int sz_tab[10] = '{40, 127, 41, 0, 1, 119, 120, 121, 2, 79};

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic push_col(input int col, input int sz);
    int h;
    int top;
    int bot;
    logic [2:0] c;
    h   = (sz > SCREEN_H) ? SCREEN_H : sz;
    top = (SCREEN_H - h) / 2;
    bot = top + h;
    for (int r = 0; r < SCREEN_H; r++) begin
      if (r < top)      c = CEIL_COLOUR;
      else if (r < bot) c = WALL_COLOUR;
      else              c = FLOOR_COLOUR;
      exp_q.push_back({8'(col), 7'(r), c});
    end
  endtask

  // Calculator model and output monitor
  initial begin
    int sz;
    logic [17:0] e;
    bus.calc_done  = 1'b0;
    bus.slice_size = 7'd0;
    forever begin
      @(negedge clock);
      cyc++;
      if (!resetn) begin
        exp_q.delete();
        lat_q.delete();
        cd_cnt = 0;
      end
      if (!busy) exp_col = 0;
      if (stuck) bus.calc_done = 1'b1;
      if (bus.calc_begin) begin
        n_begin++;
        chk("col_idx", 32'(bus.column_count), 32'(exp_col));
        cur_col = exp_col;
        exp_col++;
        t_req = cyc;
        if (stuck) begin
          push_col(cur_col, 0);
          lat_q.push_back(TMO + 1);
        end else begin
          bus.calc_done = 1'b0;
          cd_cnt = dly;
        end
      end else if (cd_cnt > 0) begin
        cd_cnt--;
        if (cd_cnt == 0) begin
          sz = (sz_idx < 10) ? sz_tab[sz_idx] : int'($urandom_range(0, 127));
          sz_idx++;
          bus.slice_size = 7'(sz);
          bus.calc_done  = 1'b1;
          push_col(cur_col, sz);
          lat_q.push_back(dly + 1);
        end
      end
      if (bus.plot) begin
        n_plot++;
        if (exp_q.size() == 0) begin
          chk("sb_depth", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          chk("pixel", 32'({bus.x, bus.y, bus.colour}), 32'(e));
        end
        if (bus.y == 7'd0) begin
          if (lat_q.size() == 0)
            chk("lat_depth", 32'(lat_q.size()), 32'd1);
          else
            chk("latency", 32'(cyc - t_req), 32'(lat_q.pop_front()));
        end
      end
      if (frame_done) n_fd++;
    end
  end

  task automatic do_reset(input string tag);
    resetn = 1'b0;
    @(negedge clock);
    chk(tag, 32'({bus.calc_begin, bus.column_count, bus.plot, bus.x,
                  bus.y, bus.colour, busy, frame_done}), 32'd0);
    @(negedge clock);
    resetn = 1'b1;
  endtask

  task automatic pulse_start();
    @(negedge clock);
    start_frame = 1'b1;
    @(negedge clock);
    start_frame = 1'b0;
  endtask

  initial begin
    int b0;
    int p0;
    int f0;
    bit hit;

    @(negedge clock);
    do_reset("reset_outs");

    // Full frame, mid-frame start pulses must be ignored
    b0 = n_begin;
    p0 = n_plot;
    pulse_start();
    for (int i = 0; i < 25000 && n_fd == 0; i++) begin
      @(negedge clock);
      start_frame = (i % 4000 == 1000);
    end
    start_frame = 1'b0;
    chk("frame_done", 32'(n_fd), 32'd1);
    chk("calc_begins", 32'(n_begin - b0), 32'(SCREEN_W));
    chk("plots", 32'(n_plot - p0), 32'(SCREEN_W * SCREEN_H));
    chk("sb_left", 32'(exp_q.size()), 32'd0);
    repeat (10) @(negedge clock);
    chk("fd_once", 32'(n_fd), 32'd1);
    chk("idle_busy", 32'(busy), 32'd0);

    // Calculator stuck high: the column times out and draws h=0
    stuck = 1'b1;
    repeat (3) @(negedge clock);
    p0 = n_plot;
    pulse_start();
    for (int i = 0; i < 800 && n_plot < p0 + SCREEN_H; i++)
      @(negedge clock);
    chk("tmo_plots", 32'(n_plot - p0), 32'(SCREEN_H));
    stuck = 1'b0;
    do_reset("tmo_reset");

    // Abort mid-frame at column 57, row 10
    f0 = n_fd;
    hit = 1'b0;
    pulse_start();
    for (int i = 0; i < 12000; i++) begin
      @(negedge clock);
      if (bus.plot && bus.x == 8'd57 && bus.y == 7'd10) begin
        hit = 1'b1;
        break;
      end
    end
    chk("hit_57_10", 32'(hit), 32'd1);
    do_reset("abort_outs");
    repeat (20) @(negedge clock);
    chk("abort_no_fd", 32'(n_fd), 32'(f0));

    // Restart begins again at column 0
    p0 = n_plot;
    pulse_start();
    for (int i = 0; i < 600 && n_plot < p0 + 2 * SCREEN_H; i++)
      @(negedge clock);
    chk("restart_plots", 32'(n_plot - p0), 32'(2 * SCREEN_H));
    chk("restart_busy", 32'(busy), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
